oai33_zn_deglitch_capture: RTL
==============================

// Module: oai33_zn_deglitch_capture
// PURPOSE
//  Downstream capture stage for the OAI33 ZN net. Synchronises ZN into the CLK domain and
//  rejects glitches shorter than FILT_CYCLES. Exposes a stable level, plus a one-deep
//  valid/ready edge-event interface, a saturating edge counter and a sticky overflow flag.
//  Sits between a combinational OAI33 decode and the consuming sequential logic.
// PARAMETERS
//  SYNC_STAGES  2  synchroniser depth; legal 2..4
//  FILT_CYCLES  4  consecutive sampled cycles a new level must persist before commit; legal 1..15
//  CNT_W        4  width of EDGE_CNT; saturates at all-ones
//  RST_VAL      1  reset level of the sync chain and Q; 1 matches OAI33 ZN with all inputs low
// PORTS
//  CLK       in   1      rising-edge clock
//  RN        in   1      asynchronous active-low reset
//  ZN        in   1      raw OAI33 output, asynchronous to CLK
//  EVT_READY in   1      consumer accepts the pending event
//  CLR       in   1      synchronous clear of EVT_OVF and EDGE_CNT
//  Q         out  1      filtered, committed level
//  EVT_VALID out  1      an edge event is pending
//  EVT_RISE  out  1      pending event type: 1 = rising (Q 0->1), 0 = falling
//  EDGE_CNT  out  CNT_W  committed-edge count, saturating
//  EVT_OVF   out  1      sticky: an edge was dropped because an event was already pending
//  VDD/VSS   inout 1     present only under USE_POWER_PINS
// BEHAVIOUR
//  - RN low (async): sync chain = RST_VAL, Q = RST_VAL, filter count = 0, EVT_VALID = 0,
//    EVT_RISE = 0, EDGE_CNT = 0, EVT_OVF = 0. Reset release takes effect at the next CLK edge.
//    Assertion mid-operation discards any pending event and partial filter count.
//  - Sync: S = last stage of the SYNC_STAGES flop chain on ZN.
//  - Filter: when S == Q, count <= 0.
//    When S != Q and count < FILT_CYCLES-1, count <= count+1.
//    When S != Q and count == FILT_CYCLES-1, this is a commit: Q <= S and count <= 0.
//    FILT_CYCLES=1 commits on the first differing sample.
//  - Latency: a clean ZN step is visible on Q exactly SYNC_STAGES+FILT_CYCLES edges later.
//    With defaults this is 6 cycles.
//  - A pulse narrower than FILT_CYCLES sampled cycles never reaches Q and generates no event.
//    A reversal mid-count resets the count to 0.
//  - Events: a commit in cycle t raises EVT_VALID at t+1, with EVT_RISE = new Q.
//  - Handshake: the transfer occurs on any edge where EVT_VALID && EVT_READY.
//    EVT_VALID/EVT_RISE stay stable until the transfer. EVT_READY while !EVT_VALID is ignored.
//  - Commit with a transfer in the same cycle: the new event loads and EVT_VALID stays 1.
//  - Commit while EVT_VALID=1 and no transfer: the new event is dropped, the old event is
//    kept, and EVT_OVF <= 1.
//  - EDGE_CNT increments on every commit, including dropped events. It holds at 2^CNT_W-1.
//  - CLR clears EVT_OVF and EDGE_CNT next edge. It does not affect Q, the filter or the event.
//    If CLR and a commit coincide, the commit wins: EDGE_CNT <= 1, and EVT_OVF <= 1 if dropped.
// STRUCTURE
//  - Shared package gf180mcu_fd_sc_mcu7t5v0_pkg: EVT_FALL=1'b0 / EVT_RISE=1'b1 encodings,
//    plus SYNC_STAGES_MIN/MAX and FILT_CYCLES_MAX legality bounds.
//  - One sub-module: oai33_zn_sync (parameterised SYNC_STAGES flop chain, async RN, RST_VAL).
//  - Filter, event register and counter stay in this module.
//  - Elaboration-time check on parameter ranges.
// TESTING
//  1 Reset: RN=0 with ZN toggling -> Q=1, EVT_VALID=0, EDGE_CNT=0, EVT_OVF=0.
//    Release, ZN=1 steady for 20 cycles -> no events.
//  2 Clean step: ZN 1->0 at cycle 0, EVT_READY=1 -> Q=0 at edge 6.
//    EVT_VALID=1 with EVT_RISE=0 at edge 7 for one cycle. EDGE_CNT=1.
//  3 Glitch: ZN low for 3 cycles, then high -> Q stays 1, no event, count returns to 0.
//    A 4-cycle low pulse -> one falling commit, then one rising commit.
//  4 Backpressure: EVT_READY=0, two committed edges -> EVT_VALID=1, EVT_RISE=0 (first edge kept).
//    EVT_OVF=1, EDGE_CNT=2. Then READY=1 -> EVT_VALID=0 next edge.
//  5 Coincidence: commit in the same cycle as an accepted transfer -> new event loaded, no overflow.
//    CLR with a commit in the same cycle -> EDGE_CNT=1.
//  6 Saturation/reset: CNT_W=2, six edges -> EDGE_CNT=3.
//    RN pulse mid-filter (count=2) -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/gf180mcu_fd_sc_mcu7t5v0_pkg.sv
// Shared encodings and legal parameter bounds for the
// OAI33 ZN deglitch capture slice.
package gf180mcu_fd_sc_mcu7t5v0_pkg;

    localparam logic EVT_FALL = 1'b0;
    localparam logic EVT_RISE = 1'b1;

    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 4;
    localparam int FILT_CYCLES_MIN = 1;
    localparam int FILT_CYCLES_MAX = 15;

    // Wide enough for FILT_CYCLES_MAX-1
    localparam int FILT_CNT_W = 4;

endpackage

// File: rtl/oai33_zn_deglitch_capture_sync.sv
// Flop-chain synchroniser bringing the raw ZN net into the CLK domain.
// Resets to RST_VAL so the chain agrees with Q out of reset.
module oai33_zn_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b1
) (
    input  logic CLK,
    input  logic RN,
    input  logic ZN,
    output logic S
);

    logic [SYNC_STAGES-1:0] chain;

    // Shift ZN through the chain, oldest sample at the top
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            chain <= {SYNC_STAGES{RST_VAL}};
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], ZN};
        end
    end

    assign S = chain[SYNC_STAGES-1];

endmodule

// File: rtl/oai33_zn_deglitch_capture.sv
// Capture stage for the OAI33 ZN net: sync, glitch filter, one-deep
// edge-event register, saturating edge counter and sticky overflow.
module oai33_zn_deglitch_capture #(
    parameter int   SYNC_STAGES = 2,
    parameter int   FILT_CYCLES = 4,
    parameter int   CNT_W       = 4,
    parameter logic RST_VAL     = 1'b1
) (
`ifdef USE_POWER_PINS
    inout  wire              VDD,
    inout  wire              VSS,
`endif
    input  logic             CLK,
    input  logic             RN,
    input  logic             ZN,
    input  logic             EVT_READY,
    input  logic             CLR,
    output logic             Q,
    output logic             EVT_VALID,
    output logic             EVT_RISE,
    output logic [CNT_W-1:0] EDGE_CNT,
    output logic             EVT_OVF
);

    import gf180mcu_fd_sc_mcu7t5v0_pkg::*;

    if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_sync
        $error("oai33_zn_deglitch_capture: SYNC_STAGES out of range");
    end
    if (FILT_CYCLES < FILT_CYCLES_MIN || FILT_CYCLES > FILT_CYCLES_MAX) begin : g_bad_filt
        $error("oai33_zn_deglitch_capture: FILT_CYCLES out of range");
    end
    if (CNT_W < 1) begin : g_bad_cnt
        $error("oai33_zn_deglitch_capture: CNT_W must be at least 1");
    end

    localparam logic [FILT_CNT_W-1:0] FILT_LAST = FILT_CNT_W'(FILT_CYCLES - 1);
    localparam logic [CNT_W-1:0]      CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1);

    logic                  s;
    logic [FILT_CNT_W-1:0] filt_cnt;
    logic                  commit;
    logic                  commit_r;
    logic                  commit_rise;
    logic                  xfer;
    logic                  drop;

    oai33_zn_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .RST_VAL     (RST_VAL)
    ) u_sync (
        .CLK (CLK),
        .RN  (RN),
        .ZN  (ZN),
        .S   (s)
    );

    // A differing sample that completes the persistence window commits
    always_comb begin
        commit = (s != Q) && (filt_cnt == FILT_LAST);
    end

    // Persistence counter and committed level; any reversal restarts the count
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            Q        <= RST_VAL;
            filt_cnt <= '0;
        end else if (s == Q) begin
            filt_cnt <= '0;
        end else if (commit) begin
            Q        <= s;
            filt_cnt <= '0;
        end else begin
            filt_cnt <= filt_cnt + 1'b1;
        end
    end

    // Register the commit so the event appears the cycle after Q moves
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            commit_r    <= 1'b0;
            commit_rise <= EVT_FALL;
        end else begin
            commit_r    <= commit;
            commit_rise <= s;
        end
    end

    assign xfer = EVT_VALID && EVT_READY;
    assign drop = commit_r && EVT_VALID && !EVT_READY;

    // One-deep event slot: a new edge loads unless an old one is still held
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            EVT_VALID <= 1'b0;
            EVT_RISE  <= EVT_FALL;
        end else if (commit_r && !drop) begin
            EVT_VALID <= 1'b1;
            EVT_RISE  <= commit_rise;
        end else if (xfer) begin
            EVT_VALID <= 1'b0;
        end
    end

    // Saturating edge count; a commit overrides a coincident clear
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            EDGE_CNT <= '0;
        end else if (commit_r) begin
            if (CLR) begin
                EDGE_CNT <= CNT_ONE;
            end else if (EDGE_CNT != CNT_MAX) begin
                EDGE_CNT <= EDGE_CNT + CNT_ONE;
            end
        end else if (CLR) begin
            EDGE_CNT <= '0;
        end
    end

    // Sticky overflow on a dropped edge; a drop beats a coincident clear
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            EVT_OVF <= 1'b0;
        end else if (drop) begin
            EVT_OVF <= 1'b1;
        end else if (CLR) begin
            EVT_OVF <= 1'b0;
        end
    end

endmodule
